countdown_timer: RTL and testbench

//   Loadable down-counter timer: the consuming counterpart to the free-running up-counter.

---
 rtl/timer_pkg.sv | 14 +
 rtl/tick_prescaler.sv | 31 +++
 rtl/countdown_timer.sv | 117 +++++++++++
 tb/tb_countdown_timer.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/timer_pkg.sv
// Shared types and defaults for the countdown timer.
package timer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } timer_state_t;

  localparam int DEFAULT_WIDTH    = 16;
  localparam int DEFAULT_PRESCALE = 1;

endpackage

// File: rtl/tick_prescaler.sv
// Divides enabled clock cycles down to one tick every PRESCALE enabled cycles.
// With PRESCALE==1 the counter stays at zero and tick follows en combinationally.
module tick_prescaler #(
  parameter int PRESCALE = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

  logic [CW-1:0] prescale_cnt_reg;

  assign tick = en && (prescale_cnt_reg == LAST);

  // Count enabled cycles, wrapping on the tick; clr restarts the phase.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prescale_cnt_reg <= '0;
    end else if (clr) begin
      prescale_cnt_reg <= '0;
    end else if (en) begin
      prescale_cnt_reg <= tick ? '0 : prescale_cnt_reg + 1'b1;
    end
  end

endmodule

// File: rtl/countdown_timer.sv
// Loadable down-counter timer with prescaled decrement, pause, abort and
// optional auto-reload. Expiry is a registered one-cycle pulse.
module countdown_timer
  import timer_pkg::*;
#(
  parameter int WIDTH    = DEFAULT_WIDTH,
  parameter int PRESCALE = DEFAULT_PRESCALE
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] load_value,
  input  logic             auto_reload,
  output logic             load_ready,
  input  logic             start,
  input  logic             pause,
  input  logic             stop,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             expired,
  output logic             done
);

  timer_state_t     state_reg;
  logic [WIDTH-1:0] count_reg;
  logic [WIDTH-1:0] reload_reg;
  logic             reload_mode_reg;
  logic             expired_reg;
  logic             done_reg;
  logic             tick;
  logic             presc_en;
  logic             presc_clr;
  logic             load_accept;

  // The prescaler only advances while running; an abort squashes any tick
  // in the same cycle, and both abort and start restart its phase.
  assign presc_en    = (state_reg == RUN) && !stop;
  assign presc_clr   = stop || ((state_reg == IDLE) && start);
  assign load_ready  = (state_reg == IDLE) || (state_reg == DONE);
  assign load_accept = load_valid && load_ready;

  tick_prescaler #(.PRESCALE(PRESCALE)) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .en   (presc_en),
    .clr  (presc_clr),
    .tick (tick)
  );

  // Control FSM with count/reload registers; priority stop > load > start > pause.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg       <= IDLE;
      count_reg       <= '0;
      reload_reg      <= '0;
      reload_mode_reg <= 1'b0;
      expired_reg     <= 1'b0;
      done_reg        <= 1'b0;
    end else begin
      expired_reg <= 1'b0;
      if (stop) begin
        state_reg <= IDLE;
        done_reg  <= 1'b0;
      end else if (load_accept) begin
        count_reg       <= load_value;
        reload_reg      <= load_value;
        reload_mode_reg <= auto_reload;
        state_reg       <= IDLE;
        done_reg        <= 1'b0;
      end else begin
        case (state_reg)
          IDLE: begin
            if (start) begin
              if (count_reg == '0) begin
                // Nothing to count: expire immediately.
                state_reg   <= DONE;
                done_reg    <= 1'b1;
                expired_reg <= 1'b1;
              end else begin
                state_reg <= RUN;
              end
            end
          end
          RUN: begin
            if (tick && (count_reg == WIDTH'(1))) begin
              expired_reg <= 1'b1;
              if (reload_mode_reg) begin
                count_reg <= reload_reg;
                if (pause) state_reg <= PAUSE;
              end else begin
                count_reg <= '0;
                state_reg <= DONE;
                done_reg  <= 1'b1;
              end
            end else begin
              if (tick && (count_reg != '0)) count_reg <= count_reg - 1'b1;
              if (pause) state_reg <= PAUSE;
            end
          end
          PAUSE: begin
            if (!pause) state_reg <= RUN;
          end
          DONE: begin
            state_reg <= DONE;
          end
          default: state_reg <= IDLE;
        endcase
      end
    end
  end

  assign count   = count_reg;
  assign busy    = (state_reg == RUN) || (state_reg == PAUSE);
  assign expired = expired_reg;
  assign done    = done_reg;

endmodule

// File: tb/tb_countdown_timer.sv
// Directed bench for countdown_timer: a vector table for single-cycle
// behaviour plus hand sequences for prescaled reload, pause and reset.
module tb_countdown_timer;

  logic        clk = 1'b0;
  logic        rst;
  logic        load_valid;
  logic [15:0] load_value;
  logic        auto_reload;
  logic        start;
  logic        pause;
  logic        stop;

  logic        load_ready, busy, expired, done;
  logic [15:0] count;
  logic        load_ready4, busy4, expired4, done4;
  logic [15:0] count4;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  countdown_timer #(.WIDTH(16), .PRESCALE(1)) dut (
    .clk(clk), .rst(rst), .load_valid(load_valid), .load_value(load_value),
    .auto_reload(auto_reload), .load_ready(load_ready), .start(start),
    .pause(pause), .stop(stop), .count(count), .busy(busy),
    .expired(expired), .done(done)
  );

  countdown_timer #(.WIDTH(16), .PRESCALE(4)) dut4 (
    .clk(clk), .rst(rst), .load_valid(load_valid), .load_value(load_value),
    .auto_reload(auto_reload), .load_ready(load_ready4), .start(start),
    .pause(pause), .stop(stop), .count(count4), .busy(busy4),
    .expired(expired4), .done(done4)
  );

  typedef struct {
    logic        lv;
    logic [15:0] lval;
    logic        ar;
    logic        st;
    logic        pa;
    logic        sp;
    logic [15:0] e_count;
    logic        e_busy;
    logic        e_expired;
    logic        e_done;
    logic        e_ready;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(logic lv, logic [15:0] lval, logic ar, logic st,
                              logic pa, logic sp, logic [15:0] ec, logic eb,
                              logic ee, logic ed, logic er);
    vec_t v;
    v.lv = lv; v.lval = lval; v.ar = ar; v.st = st; v.pa = pa; v.sp = sp;
    v.e_count = ec; v.e_busy = eb; v.e_expired = ee; v.e_done = ed; v.e_ready = er;
    return v;
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d] got=%0h want=%0h", name, idx, act, exp);
    end
  endtask

  task automatic idle_inputs();
    load_valid = 0; load_value = '0; auto_reload = 0;
    start = 0; pause = 0; stop = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int exp_at;
    int n;
    idle_inputs();
    rst = 1'b1;
    step();
    step();
    chk("rst_count", 0, count, 16'h0);
    chk("rst_busy", 0, busy, 0);
    chk("rst_expired", 0, expired, 0);
    chk("rst_done", 0, done, 0);
    chk("rst_ready", 0, load_ready, 1);
    rst = 1'b0;

    //          lv lval ar st pa sp  count busy exp done ready
    // basic one-shot countdown of 5
    vq.push_back(mk(1, 5, 0, 0, 0, 0, 5, 0, 0, 0, 1));
    vq.push_back(mk(0, 0, 0, 1, 0, 0, 5, 1, 0, 0, 0));
    vq.push_back(mk(0, 0, 0, 0, 0, 0, 4, 1, 0, 0, 0));
    vq.push_back(mk(0, 0, 0, 0, 0, 0, 3, 1, 0, 0, 0));
    vq.push_back(mk(0, 0, 0, 0, 0, 0, 2, 1, 0, 0, 0));
    vq.push_back(mk(0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0));
    vq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1));
    vq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1));
    vq.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 1));  // start ignored in DONE
    // zero load: straight to DONE with a single pulse
    vq.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    vq.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 1, 1, 1));
    vq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1));
    // stop on the terminal tick
    vq.push_back(mk(1, 2, 0, 0, 0, 0, 2, 0, 0, 0, 1));
    vq.push_back(mk(0, 0, 0, 1, 0, 0, 2, 1, 0, 0, 0));
    vq.push_back(mk(0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0));
    vq.push_back(mk(0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 1));
    // restart from 1; load while busy is ignored
    vq.push_back(mk(0, 0, 0, 1, 0, 0, 1, 1, 0, 0, 0));
    vq.push_back(mk(1, 9, 0, 0, 0, 0, 0, 0, 1, 1, 1));
    // stop clears done; stop beats load
    vq.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1));
    vq.push_back(mk(1, 7, 0, 0, 0, 1, 0, 0, 0, 0, 1));
    // reload value 1 pulses every cycle; stop suppresses the expiry
    vq.push_back(mk(1, 1, 1, 0, 0, 0, 1, 0, 0, 0, 1));
    vq.push_back(mk(0, 0, 0, 1, 0, 0, 1, 1, 0, 0, 0));
    vq.push_back(mk(0, 0, 0, 0, 0, 0, 1, 1, 1, 0, 0));
    vq.push_back(mk(0, 0, 0, 0, 0, 0, 1, 1, 1, 0, 0));
    vq.push_back(mk(0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 1));
    // pause coincident with the terminal tick: tick completes into DONE
    vq.push_back(mk(1, 2, 0, 0, 0, 0, 2, 0, 0, 0, 1));
    vq.push_back(mk(0, 0, 0, 1, 0, 0, 2, 1, 0, 0, 0));
    vq.push_back(mk(0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0));
    vq.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 1, 1, 1));

    for (int i = 0; i < vq.size(); i++) begin
      load_valid = vq[i].lv; load_value = vq[i].lval; auto_reload = vq[i].ar;
      start = vq[i].st; pause = vq[i].pa; stop = vq[i].sp;
      step();
      chk("vec_count", i, count, vq[i].e_count);
      chk("vec_busy", i, busy, vq[i].e_busy);
      chk("vec_expired", i, expired, vq[i].e_expired);
      chk("vec_done", i, done, vq[i].e_done);
      chk("vec_ready", i, load_ready, vq[i].e_ready);
      $display("vec %0d: count=%0d busy=%0b expired=%0b done=%0b ready=%0b",
               i, count, busy, expired, done, load_ready);
    end

    // Prescaled periodic mode: load 3, PRESCALE=4 -> expiry every 12 cycles.
    idle_inputs(); stop = 1; step();
    idle_inputs(); load_valid = 1; load_value = 3; auto_reload = 1; step();
    idle_inputs(); start = 1; step();
    idle_inputs();
    for (int c = 1; c <= 36; c++) begin
      step();
      chk("p4_count", c, count4, 16'(3 - ((c / 4) % 3)));
      chk("p4_expired", c, expired4, (c % 12) == 0);
      chk("p4_busy", c, busy4, 1);
      $display("p4 cycle %0d: count=%0d expired=%0b busy=%0b", c, count4, expired4, busy4);
    end

    // Pause for 7 cycles at count 6: count holds, expiry moves from 10 to 17.
    idle_inputs(); stop = 1; step();
    idle_inputs(); load_valid = 1; load_value = 10; step();
    idle_inputs(); start = 1; step();
    idle_inputs();
    exp_at = -1;
    for (int c = 1; c <= 40 && exp_at < 0; c++) begin
      pause = (c >= 4 && c <= 10);
      step();
      if (c >= 4 && c <= 11) begin
        chk("pause_hold", c, count, 16'd6);
        chk("pause_busy", c, busy, 1);
      end
      if (expired) exp_at = c;
      $display("pause cycle %0d: count=%0d busy=%0b expired=%0b", c, count, busy, expired);
    end
    chk("pause_expiry_cycle", 0, 32'(exp_at), 32'd17);
    chk("pause_done", 0, done, 1);

    // Asynchronous reset mid-count.
    idle_inputs(); load_valid = 1; load_value = 16'h1234; step();
    idle_inputs(); start = 1; step();
    idle_inputs();
    chk("arst_pre_count", 0, count, 16'h1234);
    chk("arst_pre_busy", 0, busy, 1);
    #2 rst = 1'b1;
    #1;
    chk("arst_count", 0, count, 16'h0);
    chk("arst_busy", 0, busy, 0);
    chk("arst_expired", 0, expired, 0);
    chk("arst_done", 0, done, 0);
    chk("arst_ready", 0, load_ready, 1);
    $display("async reset: count=%0h busy=%0b ready=%0b", count, busy, load_ready);
    step();
    rst = 1'b0;
    start = 1; step();
    idle_inputs();
    chk("post_rst_expired", 0, expired, 1);
    chk("post_rst_done", 0, done, 1);
    chk("post_rst_count", 0, count, 16'h0);
    n = 0;
    for (int c = 0; c < 3; c++) begin
      step();
      if (expired) n++;
    end
    chk("post_rst_single_pulse", 0, 32'(n), 32'd0);
    $display("post reset start: done=%0b count=%0d", done, count);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
